display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the stopwatch's multi-digit 7-segment display. It holds a tear-free snapshot of NUM_DIGITS BCD digits and steps through them one at a time. For each digit it presents the 4-bit code to the single shared BCD-to-segment decoder and drives a one-hot digit select, with a dead-time gap between digits to prevent ghosting. It also provides leading-zero blanking and a frame-boundary strobe for the timekeeping logic.

---
 rtl/display_scan_ctrl_pkg.sv | 13 +
 rtl/scan_slot_timer.sv | 39 +++
 rtl/display_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment display scan controller.
package display_scan_ctrl_pkg;

    localparam int unsigned BCD_W     = 4;
    localparam logic        BLANK_SEL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter: runs 0..DIV-1, flags the last SHOW cycle and the last slot cycle.
module scan_slot_timer #(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic show_end_c,
    output logic slot_end_c
);

    localparam int unsigned       CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0]  SHOW_LAST = CNT_W'(DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Held at zero whenever the scan is not running.
    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != SLOT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign show_end_c = run && (cnt_q == SHOW_LAST);
    assign slot_end_c = run && (cnt_q == SLOT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan controller: double-buffered BCD snapshot, one-hot digit select with dead time,
// leading-zero blanking and a frame-boundary strobe.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned LZ_SUPPRESS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [BCD_W-1:0]              digit_code,
    output logic                          dp_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_done
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = BCD_W * NUM_DIGITS;

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_W-1:0]       active_q, active_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [DATA_W-1:0]       pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [BCD_W-1:0]        digit_code_q, digit_code_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_done_q, frame_done_d;

    logic                    run_c;
    logic                    show_end_c;
    logic                    slot_end_c;
    logic                    show_now;
    logic                    lead_zero;
    logic [NUM_DIGITS-1:0]   supp;

    assign run_c = en && (state_q != ST_IDLE);

    scan_slot_timer #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (run_c),
        .show_end_c (show_end_c),
        .slot_end_c (slot_end_c)
    );

    // Scan sequencing and buffer management.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;
        frame_done_d = 1'b0;
        show_now    = 1'b0;

        if (load) begin
            pend_d     = digits_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d  = ST_SHOW;
                    idx_d    = '0;
                    show_now = 1'b1;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (show_end_c) begin
                    state_d = ST_GAP;
                end else begin
                    show_now = 1'b1;
                end
            end
            ST_GAP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (slot_end_c) begin
                    state_d  = ST_SHOW;
                    show_now = 1'b1;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        // A load landing on this edge stays pending for the next frame.
                        if (pend_vld_q) begin
                            active_d    = pend_q;
                            active_dp_d = pend_dp_q;
                            pend_vld_d  = load;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Digit presentation, evaluated against the buffer contents of the coming cycle.
    always_comb begin
        digit_sel_d  = {NUM_DIGITS{BLANK_SEL}};
        digit_code_d = digit_code_q;
        dp_d         = dp_q;
        lead_zero    = 1'b1;
        supp         = '0;

        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (active_d[i*BCD_W +: BCD_W] == '0);
            supp[i]   = (LZ_SUPPRESS != 0) && (i != 0) && lead_zero;
        end

        if (show_now) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (idx_d == IDX_W'(i)) begin
                    digit_code_d = active_d[i*BCD_W +: BCD_W];
                    dp_d         = active_dp_d[i];
                    digit_sel_d  = supp[i] ? {NUM_DIGITS{BLANK_SEL}}
                                           : (NUM_DIGITS'(1) << i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            digit_code_q <= '0;
            dp_q         <= 1'b0;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            digit_code_q <= digit_code_d;
            dp_q         <= dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_code = digit_code_q;
    assign dp_out     = dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;

    logic [3:0]  code, code0;
    logic        dp, dp0;
    logic [3:0]  sel, sel0;
    logic        fd, fd0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int unsigned n;
        logic        ld;
        logic [15:0] din;
        logic [3:0]  ldp;
        logic [3:0]  sel;
        logic [3:0]  sel_nolz;
        logic [3:0]  code;
        logic        dp;
        logic        fd;
    } vec_t;

    vec_t tbl[$];

    display_scan_ctrl #(
        .NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .digit_code(code), .dp_out(dp), .digit_sel(sel), .frame_done(fd)
    );

    display_scan_ctrl #(
        .NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(0)
    ) dut_nolz (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .digit_code(code0), .dp_out(dp0), .digit_sel(sel0), .frame_done(fd0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int r, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0h want %0h", name, r, act, exp);
        end
    endtask

    task automatic push(input int unsigned n, input logic ld, input logic [15:0] din,
                        input logic [3:0] ldp, input logic [3:0] s, input logic [3:0] s0,
                        input logic [3:0] c, input logic d, input logic f);
        vec_t v;
        v.n = n; v.ld = ld; v.din = din; v.ldp = ldp;
        v.sel = s; v.sel_nolz = s0; v.code = c; v.dp = d; v.fd = f;
        tbl.push_back(v);
    endtask

    // One digit slot: 6 SHOW cycles (first may carry frame_done) then 2 GAP cycles.
    task automatic push_slot(input logic [3:0] s, input logic [3:0] s0, input logic [3:0] c,
                             input logic d, input logic f, input logic ld,
                             input logic [15:0] din, input logic [3:0] ldp);
        if (f) begin
            push(1, ld, din, ldp, s, s0, c, d, 1'b1);
            push(5, 1'b0, din, ldp, s, s0, c, d, 1'b0);
        end else begin
            push(6, ld, din, ldp, s, s0, c, d, 1'b0);
        end
        push(2, 1'b0, din, ldp, 4'b0000, 4'b0000, c, d, 1'b0);
    endtask

    task automatic wait_nolz_sel(input logic [3:0] want, input int unsigned maxc);
        int unsigned c = 0;
        while ((sel0 !== want) && (c < maxc)) begin
            tick();
            c++;
        end
        chk("wait_sel", int'(c), 32'(sel0), 32'(want));
    endtask

    initial begin
        // Frame 1: active buffer still all-zero, 1234 pending.
        push_slot(4'b0001, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0000, 4'b0010, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0000, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0000, 4'b1000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        // Frame 2: 1234 with dp on digit 2.
        push_slot(4'b0001, 4'b0001, 4'h4, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0010, 4'b0010, 4'h3, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0100, 4'b0100, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b1000, 4'b1000, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        // Frame 3: loads of 9999 then 5678 mid-frame must not tear it.
        push_slot(4'b0001, 4'b0001, 4'h4, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0010, 4'b0010, 4'h3, 1'b0, 1'b0, 1'b1, 16'h9999, 4'h0);
        push_slot(4'b0100, 4'b0100, 4'h2, 1'b1, 1'b0, 1'b1, 16'h5678, 4'h0);
        push_slot(4'b1000, 4'b1000, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        // Frame 4: 5678; load 0042 (dp digit 3) on the boundary edge itself.
        push_slot(4'b0001, 4'b0001, 4'h8, 1'b0, 1'b1, 1'b1, 16'h0042, 4'b1000);
        push_slot(4'b0010, 4'b0010, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0100, 4'b0100, 4'h6, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b1000, 4'b1000, 4'h5, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        // Frame 5: 0042 with leading zeros blanked; dp on blanked digit 3.
        push_slot(4'b0001, 4'b0001, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0010, 4'b0010, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0000, 4'b0100, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        push_slot(4'b0000, 4'b1000, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0);
        // Frame 6 boundary: no pending, 0042 stays.
        push(1, 1'b0, 16'h0000, 4'h0, 4'b0001, 4'b0001, 4'h2, 1'b0, 1'b1);

        rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        tick();
        tick();
        chk("rst_out", 0, {19'd0, sel, code, dp, fd, sel0, code0, dp0, fd0}, 32'd0);
        rst = 1'b0;

        load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100;
        tick();
        load = 1'b0;
        chk("idle_sel", 0, 32'(sel), 32'd0);

        en = 1'b1;
        for (int r = 0; r < tbl.size(); r++) begin
            for (int unsigned k = 0; k < tbl[r].n; k++) begin
                load      = (k == 0) && tbl[r].ld;
                digits_in = tbl[r].din;
                dp_in     = tbl[r].ldp;
                tick();
                load = 1'b0;
                chk("sel",      r, 32'(sel),  32'(tbl[r].sel));
                chk("sel_nolz", r, 32'(sel0), 32'(tbl[r].sel_nolz));
                chk("code",     r, 32'(code), 32'(tbl[r].code));
                chk("dp",       r, 32'(dp),   32'(tbl[r].dp));
                chk("fd",       r, 32'(fd),   32'(tbl[r].fd));
                chk("nolz_misc", r, 32'({code0, dp0, fd0}),
                    32'({tbl[r].code, tbl[r].dp, tbl[r].fd}));
            end
        end

        // Drop enable during SHOW of idx 2; queue 0777 while idle.
        digits_in = 16'h0000; dp_in = 4'h0;
        wait_nolz_sel(4'b0100, 40);
        en = 1'b0; load = 1'b1; digits_in = 16'h0777;
        tick();
        load = 1'b0;
        chk("dis_sel", 0, 32'({sel, sel0}), 32'd0);
        chk("dis_fd", 0, 32'({fd, fd0}), 32'd0);
        for (int t = 0; t < 40; t++) begin
            tick();
            chk("idle_quiet", t, 32'({sel, sel0, fd, fd0}), 32'd0);
        end

        // Re-enable: restart at idx 0 with 0042, 0777 lands at the boundary.
        en = 1'b1;
        for (int t = 1; t <= 33; t++) begin
            tick();
            if (t == 1)  chk("re_start", t, 32'({sel, code, fd}), 32'({4'b0001, 4'h2, 1'b0}));
            if (t == 9)  chk("re_idx1",  t, 32'({sel, code}), 32'({4'b0010, 4'h4}));
            if (t == 17) chk("re_idx2",  t, 32'({sel, sel0}), 32'({4'b0000, 4'b0100}));
            if (t == 32) chk("re_nofd",  t, 32'(fd), 32'd0);
            if (t == 33) chk("re_bound", t, 32'({sel, code, fd}), 32'({4'b0001, 4'h7, 1'b1}));
        end

        // Load 5555, then reset during the GAP of idx 0.
        for (int t = 34; t <= 39; t++) begin
            load = (t == 34); digits_in = 16'h5555;
            tick();
            load = 1'b0;
        end
        chk("gap_sel", 39, 32'({sel, sel0}), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", 0, {19'd0, sel, code, dp, fd, sel0, code0, dp0, fd0}, 32'd0);
        for (int t = 1; t <= 33; t++) begin
            tick();
            if (t == 1)  chk("post_rst",   t, 32'({sel, code, dp, fd}), 32'({4'b0001, 4'h0, 1'b0, 1'b0}));
            if (t == 32) chk("post_nofd",  t, 32'(fd), 32'd0);
            if (t == 33) chk("post_bound", t, 32'({sel, code, fd}), 32'({4'b0001, 4'h0, 1'b1}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
